touch_line_drawer: RTL and testbench

Rasterises successive touch-panel samples into connected line segments and emits one VRAM pixel write per clock. Sits directly upstream of the TFT driver's video-RAM write port, driving its `wr_ena`, `wr_x`, `wr_y` and `wr_data` inputs in the `cclk` domain. Uses Bresenham stepping so that fast finger motion draws continuous strokes rather than isolated dots.

---
 rtl/tft_pkg.sv | 32 +++
 rtl/bresenham_step.sv | 43 ++++
 rtl/touch_line_drawer.sv | 180 ++++++++++++++++++
 tb/tb_touch_line_drawer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// ============================================================================
// Module      : tft_pkg
// Description : Shared TFT geometry, colour width and line-drawer state enum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tft_pkg;

    localparam int X_RES   = 480;
    localparam int Y_RES   = 272;
    localparam int X_W     = 9;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } draw_state_t;

    function automatic logic signed [10:0] to_s11(input logic [8:0] v);
        return $signed({2'b00, v});
    endfunction

    function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bresenham_step.sv
// ============================================================================
// Module      : bresenham_step
// Description : Combinational next-(cx, cy, err) calculator for one pixel step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bresenham_step
    import tft_pkg::*;
(
    input  logic signed [10:0] cx,
    input  logic signed [10:0] cy,
    input  logic signed [10:0] err,
    input  logic signed [10:0] dx,
    input  logic signed [10:0] dy,
    input  logic signed [10:0] sx,
    input  logic signed [10:0] sy,
    output logic signed [10:0] nx,
    output logic signed [10:0] ny,
    output logic signed [10:0] nerr
);

    // e2 carries one extra bit so 2*err never wraps
    logic signed [11:0] w_e2;

    always_comb begin
        w_e2 = {err, 1'b0};
        nx   = cx;
        ny   = cy;
        nerr = err;
        if (w_e2 >= 12'(dy)) begin
            nerr = nerr + dy;
            nx   = cx + sx;
        end
        if (w_e2 <= 12'(dx)) begin
            nerr = nerr + dx;
            ny   = cy + sy;
        end
    end

endmodule

`default_nettype wire

// File: rtl/touch_line_drawer.sv
// ============================================================================
// Module      : touch_line_drawer
// Description : Turns touch samples into Bresenham line segments, one VRAM
//               pixel write per clock. TOUCH_LINE_JITTER_FILTER_EN drops
//               samples within Manhattan distance 1 of the previous endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module touch_line_drawer
    import tft_pkg::*;
#(
    parameter int X_MAX   = tft_pkg::X_RES - 1,
    parameter int Y_MAX   = tft_pkg::Y_RES - 1,
    parameter int COLOR_W = tft_pkg::COLOR_W
) (
    input  logic               cclk,
    input  logic               rst,
    input  logic               touch_valid,
    input  logic [8:0]         touch_x,
    input  logic [8:0]         touch_y,
    input  logic               pen_down,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               clear_busy,
    output logic               ready,
    output logic               wr_ena,
    output logic [8:0]         wr_x,
    output logic [8:0]         wr_y,
    output logic [COLOR_W-1:0] wr_data
);

    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [8:0] Y_LIM = 9'(Y_MAX);

    draw_state_t state_q, state_d;
    logic        have_prev_q, have_prev_d;
    logic [8:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic signed [10:0] cx_q, cx_d, cy_q, cy_d, err_q, err_d;
    logic signed [10:0] dx_q, dx_d, dy_q, dy_d, sx_q, sx_d, sy_q, sy_d;
    logic        wr_ena_q, wr_ena_d;
    logic [8:0]  wr_x_q, wr_x_d, wr_y_q, wr_y_d;
    logic [COLOR_W-1:0] wr_data_q, wr_data_d;

    logic [8:0]         w_clx, w_cly;
    logic               w_jitter;
    logic signed [10:0] w_nx, w_ny, w_nerr, w_dx, w_dy;

    assign w_clx = (touch_x > X_LIM) ? X_LIM : touch_x;
    assign w_cly = (touch_y > Y_LIM) ? Y_LIM : touch_y;

`ifdef TOUCH_LINE_JITTER_FILTER_EN
    logic signed [10:0] w_dist;
    assign w_dist   = abs11(to_s11(w_clx) - to_s11(x0_q))
                    + abs11(to_s11(w_cly) - to_s11(y0_q));
    assign w_jitter = have_prev_q && (w_dist <= 11'sd1);
`else
    assign w_jitter = 1'b0;
`endif

    assign w_dx  = abs11(to_s11(x1_q) - to_s11(x0_q));
    assign w_dy  = -abs11(to_s11(y1_q) - to_s11(y0_q));
    assign ready = (state_q == IDLE) && !clear_busy;

    bresenham_step u_step (
        .cx   (cx_q),
        .cy   (cy_q),
        .err  (err_q),
        .dx   (dx_q),
        .dy   (dy_q),
        .sx   (sx_q),
        .sy   (sy_q),
        .nx   (w_nx),
        .ny   (w_ny),
        .nerr (w_nerr)
    );

    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        x0_d = x0_q;  y0_d = y0_q;
        x1_d = x1_q;  y1_d = y1_q;
        color_d = color_q;
        cx_d = cx_q;  cy_d = cy_q;  err_d = err_q;
        dx_d = dx_q;  dy_d = dy_q;  sx_d = sx_q;  sy_d = sy_q;
        wr_ena_d  = 1'b0;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (!pen_down) begin
                    have_prev_d = 1'b0;
                end else if (touch_valid && ready && !w_jitter) begin
                    x1_d    = w_clx;
                    y1_d    = w_cly;
                    color_d = color_in;
                    // Without a previous endpoint the segment degenerates to a dot
                    if (!have_prev_q) begin
                        x0_d = w_clx;
                        y0_d = w_cly;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (clear_busy) begin
                    have_prev_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    dx_d    = w_dx;
                    dy_d    = w_dy;
                    err_d   = w_dx + w_dy;
                    sx_d    = (x1_q >= x0_q) ? 11'sd1 : -11'sd1;
                    sy_d    = (y1_q >= y0_q) ? 11'sd1 : -11'sd1;
                    cx_d    = to_s11(x0_q);
                    cy_d    = to_s11(y0_q);
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (clear_busy) begin
                    have_prev_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    wr_ena_d  = 1'b1;
                    wr_x_d    = cx_q[8:0];
                    wr_y_d    = cy_q[8:0];
                    wr_data_d = color_q;
                    if (cx_q == to_s11(x1_q) && cy_q == to_s11(y1_q)) begin
                        x0_d        = x1_q;
                        y0_d        = y1_q;
                        have_prev_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cx_d  = w_nx;
                        cy_d  = w_ny;
                        err_d = w_nerr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            have_prev_q <= 1'b0;
            x0_q <= '0;  y0_q <= '0;  x1_q <= '0;  y1_q <= '0;
            color_q <= '0;
            cx_q <= '0;  cy_q <= '0;  err_q <= '0;
            dx_q <= '0;  dy_q <= '0;  sx_q <= '0;  sy_q <= '0;
            wr_ena_q  <= 1'b0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            x0_q <= x0_d;  y0_q <= y0_d;  x1_q <= x1_d;  y1_q <= y1_d;
            color_q <= color_d;
            cx_q <= cx_d;  cy_q <= cy_d;  err_q <= err_d;
            dx_q <= dx_d;  dy_q <= dy_d;  sx_q <= sx_d;  sy_q <= sy_d;
            wr_ena_q  <= wr_ena_d;
            wr_x_q    <= wr_x_d;
            wr_y_q    <= wr_y_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_ena  = wr_ena_q;
    assign wr_x    = wr_x_q;
    assign wr_y    = wr_y_q;
    assign wr_data = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_touch_line_drawer.sv
// ============================================================================
// Module      : tb_touch_line_drawer
// Description : Directed self-checking bench for touch_line_drawer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_touch_line_drawer;

    logic       cclk = 1'b0;
    logic       rst = 1'b1;
    logic       touch_valid = 1'b0;
    logic [8:0] touch_x = '0;
    logic [8:0] touch_y = '0;
    logic       pen_down = 1'b0;
    logic [8:0] color_in = '0;
    logic       clear_busy = 1'b0;
    logic       ready;
    logic       wr_ena;
    logic [8:0] wr_x;
    logic [8:0] wr_y;
    logic [8:0] wr_data;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    logic [8:0] cap_x [0:4095];
    logic [8:0] cap_y [0:4095];
    logic [8:0] cap_d [0:4095];

    touch_line_drawer dut (
        .cclk        (cclk),
        .rst         (rst),
        .touch_valid (touch_valid),
        .touch_x     (touch_x),
        .touch_y     (touch_y),
        .pen_down    (pen_down),
        .color_in    (color_in),
        .clear_busy  (clear_busy),
        .ready       (ready),
        .wr_ena      (wr_ena),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data)
    );

    always #5 cclk = ~cclk;

    // Write capture, sampled just after each active edge
    always @(posedge cclk) begin
        #1;
        if (wr_ena === 1'b1) begin
            if (n_wr < 4096) begin
                cap_x[n_wr] = wr_x;
                cap_y[n_wr] = wr_y;
                cap_d[n_wr] = wr_data;
            end
            n_wr = n_wr + 1;
        end
    end

    task automatic accept(input logic [8:0] x, input logic [8:0] y, input logic [8:0] c);
        @(negedge cclk);
        touch_x = x; touch_y = y; color_in = c;
        pen_down = 1'b1; touch_valid = 1'b1;
        @(posedge cclk);
        #1 touch_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        @(negedge cclk);
        while (ready !== 1'b1 && k < budget) begin
            @(negedge cclk);
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL wait_done: ready=%b after %0d cycles, required 1", ready, k);
        end
        @(negedge cclk);
        @(negedge cclk);
    endtask

    task automatic pen_up();
        @(negedge cclk);
        pen_down = 1'b0;
        @(negedge cclk);
        @(negedge cclk);
        pen_down = 1'b1;
    endtask

    task automatic test_reset();
        int base;
        repeat (3) @(negedge cclk);
        checks++;
        if ({wr_ena, wr_x, wr_y, wr_data} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ena=%b x=%0d y=%0d d=%h, required all 0", wr_ena, wr_x, wr_y, wr_data);
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready); end
        rst = 1'b0;
        clear_busy = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL ready_gated: got %b required 0", ready); end
        // Sample coinciding with clear_busy must be dropped
        base = n_wr;
        touch_x = 9'd5; touch_y = 9'd5; pen_down = 1'b1; touch_valid = 1'b1;
        @(negedge cclk);
        touch_valid = 1'b0;
        clear_busy  = 1'b0;
        repeat (6) @(negedge cclk);
        checks++;
        if (n_wr - base !== 0) begin errors++; $display("FAIL busy_drop: got %0d writes required 0", n_wr - base); end
    endtask

    task automatic test_first_dot();
        int base = n_wr;
        accept(9'd10, 9'd20, 9'h1C0);
        @(negedge cclk);
        @(negedge cclk);
        checks++;
        if (wr_ena !== 1'b0) begin errors++; $display("FAIL dot_early: wr_ena=%b required 0", wr_ena); end
        @(negedge cclk);
        checks++;
        if (wr_ena !== 1'b1 || wr_x !== 9'd10 || wr_y !== 9'd20 || wr_data !== 9'h1C0) begin
            errors++;
            $display("FAIL dot_latency: got ena=%b (%0d,%0d) d=%h, required 1 (10,20) 1c0", wr_ena, wr_x, wr_y, wr_data);
        end
        wait_done(50);
        checks++;
        if (n_wr - base !== 1) begin errors++; $display("FAIL dot_count: got %0d required 1", n_wr - base); end
    endtask

    task automatic test_line();
        int base = n_wr;
        int ex [6] = '{10, 11, 12, 13, 14, 15};
        int ey [6] = '{20, 20, 21, 21, 22, 22};
        accept(9'd15, 9'd22, 9'h1C0);
        // Sample offered while busy is ignored
        @(negedge cclk);
        touch_x = 9'd300; touch_y = 9'd100; touch_valid = 1'b1;
        @(negedge cclk);
        touch_valid = 1'b0;
        wait_done(50);
        checks++;
        if (n_wr - base !== 6) begin errors++; $display("FAIL line_count: got %0d required 6", n_wr - base); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (int'(cap_x[base+i]) != ex[i] || int'(cap_y[base+i]) != ey[i] || cap_d[base+i] !== 9'h1C0) begin
                errors++;
                $display("FAIL line_pix%0d: got (%0d,%0d) d=%h required (%0d,%0d) d=1c0",
                         i, cap_x[base+i], cap_y[base+i], cap_d[base+i], ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_clamp();
        int base = n_wr;
        int bad = 0;
        accept(9'd500, 9'd300, 9'h03F);
        wait_done(2000);
        checks++;
        if (n_wr - base !== 465) begin errors++; $display("FAIL clamp_count: got %0d required 465", n_wr - base); end
        checks++;
        if (cap_x[n_wr-1] !== 9'd479 || cap_y[n_wr-1] !== 9'd271) begin
            errors++;
            $display("FAIL clamp_end: got (%0d,%0d) required (479,271)", cap_x[n_wr-1], cap_y[n_wr-1]);
        end
        for (int i = base; i < n_wr; i++)
            if (cap_x[i] > 9'd479 || cap_y[i] > 9'd271) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clamp_range: got %0d out-of-range pixels required 0", bad); end
    endtask

    task automatic test_abort();
        int base = n_wr;
        int k = 0;
        accept(9'd430, 9'd271, 9'h007);
        while (n_wr - base < 4 && k < 200) begin
            @(negedge cclk);
            k++;
        end
        clear_busy = 1'b1;
        @(negedge cclk);
        checks++;
        if (wr_ena !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: got ena=%b ready=%b required 0 0", wr_ena, ready);
        end
        repeat (3) @(negedge cclk);
        clear_busy = 1'b0;
        repeat (3) @(negedge cclk);
        checks++;
        if (n_wr - base !== 4 || cap_x[n_wr-1] !== 9'd476) begin
            errors++;
            $display("FAIL abort_count: got %0d writes last x=%0d required 4 last x=476", n_wr - base, cap_x[n_wr-1]);
        end
        base = n_wr;
        accept(9'd3, 9'd3, 9'h111);
        wait_done(50);
        checks++;
        if (n_wr - base !== 1 || cap_x[base] !== 9'd3 || cap_y[base] !== 9'd3 || cap_d[base] !== 9'h111) begin
            errors++;
            $display("FAIL abort_dot: got %0d writes (%0d,%0d) required 1 (3,3)", n_wr - base, cap_x[base], cap_y[base]);
        end
    endtask

    task automatic test_reset_mid_draw();
        int base;
        int k = 0;
        pen_up();
        base = n_wr;
        accept(9'd0, 9'd0, 9'h0AA);
        wait_done(50);
        checks++;
        if (n_wr - base !== 1) begin errors++; $display("FAIL penup_dot: got %0d writes required 1", n_wr - base); end
        base = n_wr;
        accept(9'd100, 9'd0, 9'h0AA);
        while (n_wr - base < 40 && k < 200) begin
            @(negedge cclk);
            k++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({wr_ena, wr_x, wr_y, wr_data} !== 28'd0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got ena=%b x=%0d y=%0d d=%h ready=%b required 0 0 0 0 1", wr_ena, wr_x, wr_y, wr_data, ready);
        end
        @(negedge cclk);
        rst = 1'b0;
        base = n_wr;
        accept(9'd7, 9'd8, 9'h155);
        wait_done(50);
        checks++;
        if (n_wr - base !== 1 || cap_x[base] !== 9'd7 || cap_y[base] !== 9'd8 || cap_d[base] !== 9'h155) begin
            errors++;
            $display("FAIL rst_dot: got %0d writes (%0d,%0d) d=%h required 1 (7,8) 155", n_wr - base, cap_x[base], cap_y[base], cap_d[base]);
        end
    endtask

`ifdef TOUCH_LINE_JITTER_FILTER_EN
    task automatic test_jitter();
        int base;
        pen_up();
        accept(9'd50, 9'd50, 9'h0F0);
        wait_done(50);
        base = n_wr;
        accept(9'd51, 9'd50, 9'h0F0);
        repeat (6) @(negedge cclk);
        checks++;
        if (n_wr - base !== 0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL jitter_drop: got %0d writes ready=%b required 0 1", n_wr - base, ready);
        end
        accept(9'd52, 9'd50, 9'h0F0);
        wait_done(50);
        checks++;
        if (n_wr - base !== 3 || cap_x[base] !== 9'd50 || cap_x[base+1] !== 9'd51 || cap_x[base+2] !== 9'd52) begin
            errors++;
            $display("FAIL jitter_line: got %0d writes x=%0d,%0d,%0d required 3 x=50,51,52",
                     n_wr - base, cap_x[base], cap_x[base+1], cap_x[base+2]);
        end
    endtask
`else
    task automatic test_repeat_point();
        int base = n_wr;
        accept(9'd7, 9'd8, 9'h155);
        wait_done(50);
        checks++;
        if (n_wr - base !== 1 || cap_x[base] !== 9'd7 || cap_y[base] !== 9'd8) begin
            errors++;
            $display("FAIL repeat_point: got %0d writes (%0d,%0d) required 1 (7,8)", n_wr - base, cap_x[base], cap_y[base]);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_dot();
        test_line();
        test_clamp();
        test_abort();
        test_reset_mid_draw();
`ifdef TOUCH_LINE_JITTER_FILTER_EN
        test_jitter();
`else
        test_repeat_point();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
